// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU and the loader.
// Burst-limited tenures; the loader can lock ownership for program download.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_rvalid,
  output logic                  o_cpu_halt,
  input  logic                  i_ldr_req,
  input  logic                  i_ldr_we,
  input  logic [ADDR_WIDTH-1:0] i_ldr_addr,
  input  logic [DATA_WIDTH-1:0] i_ldr_wdata,
  input  logic                  i_ldr_lock,
  output logic                  o_ldr_gnt,
  output logic                  o_ldr_rvalid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_ram_we,
  output logic                  o_ram_oe,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CPU  = 2'd1;
  localparam logic [1:0] S_LDR  = 2'd2;
  localparam logic [7:0] LP_MAX = 8'(MAX_BURST);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_ptr;
  logic                  w_ptr_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  logic [7:0]            w_cnt_inc;
  logic                  r_rd_vld;
  logic                  r_rd_tag;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  w_cpu_own;
  logic                  w_ldr_own;
  logic                  w_acc_cpu;
  logic                  w_acc_ldr;
  logic                  w_acc;
  logic                  w_we;

  // r_ptr: 0 favours the CPU, 1 favours the loader
  assign w_cpu_own = (r_state == S_CPU);
  assign w_ldr_own = (r_state == S_LDR);
  assign w_acc_cpu = w_cpu_own & i_cpu_req;
  assign w_acc_ldr = w_ldr_own & i_ldr_req;
  assign w_acc     = w_acc_cpu | w_acc_ldr;
  assign w_we      = w_acc_ldr ? i_ldr_we : i_cpu_we;
  assign w_cnt_inc = (r_cnt >= LP_MAX) ? r_cnt : r_cnt + 8'd1;

  always_comb begin
    o_ram_we    = w_acc & w_we;
    o_ram_oe    = w_acc & ~w_we;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (w_acc_ldr) begin
      o_ram_addr  = i_ldr_addr;
      o_ram_wdata = i_ldr_wdata;
    end else if (w_acc_cpu) begin
      o_ram_addr  = i_cpu_addr;
      o_ram_wdata = i_cpu_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_cpu_req && (!i_ldr_req || !r_ptr)) begin
          w_state_nxt = S_CPU;
          w_ptr_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end else if (i_ldr_req) begin
          w_state_nxt = S_LDR;
          w_ptr_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_CPU: begin
        if (!i_cpu_req || (w_cnt_inc == LP_MAX && i_ldr_req)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = i_ldr_req ? S_LDR : S_IDLE;
          if (i_ldr_req) w_ptr_nxt = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_LDR: begin
        if (!i_ldr_req ||
            (w_cnt_inc == LP_MAX && i_cpu_req && !i_ldr_lock)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = i_cpu_req ? S_CPU : S_IDLE;
          if (i_cpu_req) w_ptr_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_tag  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_vld <= o_ram_oe;
      if (o_ram_oe) begin
        r_rd_tag  <= w_acc_ldr;
        r_rd_data <= i_ram_rdata;
      end
    end
  end

  assign o_cpu_gnt    = w_cpu_own;
  assign o_ldr_gnt    = w_ldr_own;
  assign o_cpu_rvalid = r_rd_vld & ~r_rd_tag;
  assign o_ldr_rvalid = r_rd_vld & r_rd_tag;
  assign o_rd_data    = r_rd_data;
  assign o_cpu_halt   = w_ldr_own |
                        ((r_state == S_IDLE) & i_ldr_req & r_ptr);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM
// (asynchronous read, write on the clock edge).
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic       cpu_gnt, cpu_rvalid, cpu_halt;
  logic       ldr_gnt, ldr_rvalid;
  logic [7:0] rd_data, ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, ram_oe;
  logic [7:0] mem [256];
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid),
    .o_cpu_halt(cpu_halt),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we),
    .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .i_ldr_lock(ldr_lock),
    .o_ldr_gnt(ldr_gnt), .o_ldr_rvalid(ldr_rvalid),
    .o_rd_data(rd_data),
    .o_ram_we(ram_we), .o_ram_oe(ram_oe),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (reset) begin
      mem[8'h0F] <= 8'hA5;
      mem[8'h20] <= 8'h3C;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h01;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h60; ldr_wdata = 8'h02;
    ldr_lock = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_outs",
        {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_halt, ram_we, ram_oe},
        7'b0);
    chk("rst_data", {rd_data, ram_addr, ram_wdata}, 24'h0);

    reset = 1'b0;
    #1;
    chk("rel_idle", {cpu_gnt, ldr_gnt, cpu_halt}, 3'b000);
    tick();

    // both requesting: CPU 4, loader 4, CPU 4
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        cpu_addr = 8'h40 + 8'(i);
        ldr_addr = 8'h60 + 8'(i);
        #1;
        if (r == 1)
          chk("cont_ldr", {cpu_gnt, ldr_gnt, cpu_halt, ram_we}, 4'b0111);
        else
          chk("cont_cpu", {cpu_gnt, ldr_gnt, cpu_halt, ram_we}, 4'b1001);
        tick();
      end
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    #1;
    chk("rel_noacc", {ldr_gnt, ram_we, ram_oe, ram_addr}, {3'b100, 8'h00});
    tick();

    // lone CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h0F;
    #1;
    chk("rd_lat", {cpu_gnt, ldr_gnt}, 2'b00);
    tick();
    #1;
    chk("rd_acc", {cpu_gnt, ram_oe, ram_we, ram_addr}, {3'b110, 8'h0F});
    tick();
    cpu_req = 1'b0;
    #1;
    chk("rd_ret", {cpu_rvalid, ldr_rvalid, rd_data}, {2'b10, 8'hA5});
    tick();

    // loader lock download
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h70;
    ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h00;
    #1;
    chk("idle_halt", {cpu_halt, cpu_gnt, ldr_gnt}, 3'b100);
    tick();
    for (int i = 0; i < 10; i++) begin
      ldr_addr  = 8'(i);
      ldr_wdata = 8'h50 + 8'(i);
      #1;
      chk("lock_wr", {ldr_gnt, cpu_gnt, cpu_halt, ram_we, ram_addr, ram_wdata},
          {4'b1011, 8'(i), 8'h50 + 8'(i)});
      tick();
    end
    ldr_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = 8'h05;
    #1;
    chk("lock_rel", {ldr_gnt, cpu_gnt, ram_we, ram_oe}, 4'b1000);
    tick();
    #1;
    chk("lock_cpu", {cpu_gnt, cpu_halt, ram_oe, ram_addr}, {3'b101, 8'h05});
    tick();
    cpu_req = 1'b0;
    #1;
    chk("lock_rb", {cpu_rvalid, ldr_rvalid, rd_data}, {2'b10, 8'h55});
    tick();

    // loader reads across an ownership change
    ldr_lock = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h20;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'h11;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ldr_rd", {ldr_gnt, ram_oe, ldr_rvalid, cpu_rvalid},
          {2'b11, (i > 0), 1'b0});
      tick();
    end
    #1;
    chk("xfer_ret", {cpu_gnt, ldr_rvalid, cpu_rvalid, rd_data},
        {3'b110, 8'h3C});
    tick();

    // reset mid-burst with a CPU read issued
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h0F;
    #1;
    chk("rst_rd_iss", {cpu_gnt, ram_oe}, 2'b11);
    tick();
    reset = 1'b0; cpu_we = 1'b1; ldr_we = 1'b1;
    #1;
    chk("rst_mid",
        {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_halt, rd_data},
        {5'b00000, 8'h00});
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rst_burst", {cpu_gnt, ldr_gnt}, {(i < 4), (i == 4)});
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
